// File: rtl/i2c_reg_slave.sv
// I2C register-file slave, oversampled on clk: 2-FF sync plus glitch filter on SCL/SDA,
// pointer byte followed by auto-incrementing data reads and writes, open-drain SDA via sda_oe.
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h2A,
  parameter int         NUM_REGS   = 4,
  parameter int         FILTER_LEN = 3,
  localparam int        PW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_index,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through the conditioning pipeline.
  logic [1:0] sync1_q, sync2_q, filt_q, filt_dly_q;
  logic [3:0] fcnt_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      filt_dly_q <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
    end else begin
      sync1_q    <= {sda_in, scl_in};
      sync2_q    <= sync1_q;
      filt_dly_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
          fcnt_q[i] <= '0;
          filt_q[i] <= sync2_q[i];
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl_hi, scl_rise, scl_fall, start_ev, stop_ev, sda_s;

  assign sda_s    = filt_q[1];
  assign scl_hi   = filt_q[0] & filt_dly_q[0];
  assign scl_rise = filt_q[0] & ~filt_dly_q[0];
  assign scl_fall = ~filt_q[0] & filt_dly_q[0];
  assign start_ev = scl_hi & filt_dly_q[1] & ~filt_q[1];
  assign stop_ev  = scl_hi & ~filt_dly_q[1] & filt_q[1];

  state_t        state_q, state_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          wstb_q, wstb_d;
  logic [PW-1:0] widx_q, widx_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];

  logic [7:0]    byte_in;
  logic [7:0]    cur_reg;
  logic [PW-1:0] ptr_nxt;
  logic          byte_ok;

  assign byte_in = {shift_q[6:0], sda_s};
  assign cur_reg = regs_q[ptr_q];
  assign ptr_nxt = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
  assign byte_ok = {1'b0, byte_in} < 9'(NUM_REGS);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wstb_d  = 1'b0;
    widx_d  = widx_q;
    regs_d  = regs_q;

    if (start_ev) begin
      state_d = S_ADDR;
      bcnt_d  = '0;
      oe_d    = 1'b0;
    end else if (stop_ev) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                  state_d = S_ADDR_ACK;
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_PTR) begin
                if (byte_ok) begin
                  ptr_d   = byte_in[PW-1:0];
                  state_d = S_PTR_ACK;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                regs_d[ptr_q] = byte_in;
                wstb_d        = 1'b1;
                widx_d        = ptr_q;
                ptr_d         = ptr_nxt;
                state_d       = S_WDATA_ACK;
              end
            end
          end
        end
        // bcnt 8: first fall drives ACK; bcnt 9: second fall releases and moves on.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (bcnt_q == 4'd8) begin
              oe_d   = 1'b1;
              bcnt_d = 4'd9;
            end else begin
              oe_d    = 1'b0;
              bcnt_d  = '0;
              state_d = S_WDATA;
              if (state_q == S_ADDR_ACK) begin
                if (rw_q) begin
                  shift_d = cur_reg;
                  oe_d    = ~cur_reg[7];
                  state_d = S_RDATA;
                end else begin
                  state_d = S_PTR;
                end
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bcnt_d = bcnt_q + 4'd1;
            if (bcnt_q == 4'd7) begin
              ptr_d   = ptr_nxt;
              state_d = S_RDATA_ACK;
            end
          end else if (scl_fall) begin
            oe_d    = ~shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        S_RDATA_ACK: begin
          if (scl_fall && bcnt_q == 4'd8) begin
            oe_d   = 1'b0;
            bcnt_d = 4'd9;
          end else if (scl_rise && bcnt_q == 4'd9) begin
            if (!sda_s) begin
              shift_d = cur_reg;
              bcnt_d  = 4'd10;
            end else begin
              state_d = S_IDLE;
            end
          end else if (scl_fall && bcnt_q == 4'd10) begin
            oe_d    = ~shift_q[7];
            bcnt_d  = '0;
            state_d = S_RDATA;
          end
        end
        default: ;
      endcase
    end

    if (state_d == S_IDLE) busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wstb_q  <= 1'b0;
      widx_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      wstb_q  <= wstb_d;
      widx_q  <= widx_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs[8*k +: 8] = regs_q[k];
  end

  assign sda_oe    = oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wstb_q;
  assign wr_index  = widx_q;

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

Parametrised, clock-synchronous I2C slave with a byte-wide register file, write and read support, and pointer auto-increment. SCL/SDA are oversampled on the system clock through a synchroniser and a glitch filter; no logic is clocked by SCL. SDA is driven open-drain through an output-enable only; the top level ties the pad output low and gates the enable with `ena`. Register contents leave the block as a flat bus for the output logic.

## Interface
- `DEV_ADDR`, default 7'h2A: 7-bit slave address.
- `NUM_REGS`, default 4: register count, 1..256. Pointer width is `PW = max(1, clog2(NUM_REGS))`.
- `FILTER_LEN`, default 3: consecutive equal samples, 1..15, required to accept a level change on SCL or SDA.

Ports:
- `clk` in 1: system clock; one clock domain, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `scl_in` in 1: raw SCL pad input.
- `sda_in` in 1: raw SDA pad input.
- `sda_oe` out 1: 1 = pull SDA low.
- `regs` out `8*NUM_REGS`: register file; reg k occupies bits [8k+7:8k].
- `wr_strobe` out 1: one-cycle pulse when a register is written.
- `wr_index` out `PW`: index written; valid while `wr_strobe`=1.
- `busy` out 1: 1 from an accepted address match until STOP or return to IDLE.

## Operation
- **Input conditioning.** Each line passes a 2-FF synchroniser, then a saturating counter filter. The filtered value changes only after `FILTER_LEN` consecutive samples differ from it.
- **Edge events.** Computed from the filtered lines, one cycle wide:
  - SCL_RISE and SCL_FALL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit handling.** Bits are sampled MSB first on SCL_RISE. `sda_oe` changes only on SCL_FALL, except that START/STOP/reset clear it immediately.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- **Global transitions.** Checked before anything else:
  - START from any state → ADDR, bit counter cleared. This covers repeated START.
  - STOP from any state → IDLE, `sda_oe`=0.
- **ADDR.** After 8 bits:
  - If addr == `DEV_ADDR` → ADDR_ACK.
  - Otherwise → IDLE (no ACK, ignore traffic until next START).
- **ADDR_ACK.** Pull SDA low for the 9th clock.
  - W: go to PTR.
  - R: go to RDATA; shift register loaded with `regs[ptr]`.
- **PTR.** Byte ≥ `NUM_REGS` → NACK, IDLE, pointer unchanged. Otherwise ptr ← byte, ACK, → WDATA.
- **WDATA.** On the 8th SCL_RISE:
  - `regs[ptr]` ← byte, `wr_strobe`=1, `wr_index`=ptr.
  - ptr ← (ptr+1) mod `NUM_REGS` (wraps to 0).
  - ACK, then WDATA again.
- **RDATA.** The MSB is driven during ADDR_ACK→RDATA SCL_FALL, or the RDATA_ACK SCL_FALL. Each bit: `sda_oe` = ~bit. After 8 bits, release SDA and go to RDATA_ACK; ptr increments with wrap when the byte's last bit is sampled.
- **RDATA_ACK.** Sample master's bit on SCL_RISE.
  - 0 (ACK): load `regs[ptr]`, → RDATA.
  - 1 (NACK): → IDLE.
- **Pointer retention.** The pointer persists across transactions (write-pointer-then-repeated-START-read supported).
- **Reset.** All `regs`=0, ptr=0, state IDLE, filtered lines=1, `sda_oe`=0, `wr_strobe`=0, `busy`=0. Reset mid-transfer aborts it; the block stays IDLE until a fresh START.

## Timing
- **Pin-to-event latency.** 2 + `FILTER_LEN` clk, plus 1 for edge detect. Pulses shorter than `FILTER_LEN` clk are rejected.
- **Clock requirement.** SCL high and low phases must each be ≥ `FILTER_LEN`+4 clk. SDA changes are valid no sooner than that after SCL_FALL.
- **ACK drive.** `sda_oe` rises 1 clk after the SCL_FALL ending bit 8 and falls 1 clk after the SCL_FALL ending bit 9.
- **Register update.** `regs` updates and `wr_strobe` pulses in the same cycle, 1 clk after the 8th-bit SCL_RISE event.
- **Simultaneous events.** START/STOP take priority over SCL edges in the same cycle. STOP during an ACK releases SDA that cycle.

## Test plan
- **Write then read.** With default parameters, START, 0x54, 0x01, 0xA5, 0x3C, STOP.
  - Expect three ACKs, then ACK.
  - Expect `regs[1]`=0xA5, `regs[2]`=0x3C, two `wr_strobe` pulses with index 1 then 2.
  - Then START, 0x54, 0x01, repeated START, 0x55: reads 0xA5 (master ACK), then 0x3C (master NACK). After STOP, `busy`=0.
- **Wrong address.** START, 0x56, …: `sda_oe` stays 0 for the whole transfer, and `regs` are unchanged.
- **Pointer out of range and wrap.**
  - Pointer 0x04 → NACK on the 9th clock, no writes.
  - Pointer 0x03 then bytes 0x11, 0x22 → `regs[3]`=0x11, `regs[0]`=0x22.
- **Glitch rejection.** A 2-clk low pulse on SDA while SCL is high, with `FILTER_LEN`=3 → no START/STOP, and state is unchanged. A 3-clk pulse is a valid START.
- **Reset mid-byte.** Assert `rst` after 4 data bits of a write → all outputs return to reset values immediately. Subsequent traffic without START is ignored; a full new transaction succeeds.
- **Parameter sweep.** Repeat the write/read scenario with `NUM_REGS`=1 (pointer always 0, wrap every byte) and `NUM_REGS`=16, `FILTER_LEN`=1.
